lcd_timing_gen: RTL and testbench
=================================

Name: lcd_timing_gen

Overview:
- Raster timing sequencer for the LCD controller.
- Consumes the horizontal/vertical timing fields (LCD_TIMH, LCD_TIMV), polarity bits (LCD_POL), and enable and VCOMP selection (LCD_CTRL).
- Generates line pulse, frame pulse and data-enable, plus pixel-fetch requests to the pixel FIFO and interrupt/base-update strobes.
- Sits between the register file and the pixel serializer; advances only on pixel-clock enable ticks from the clock divider.

Parameters:
- PPL_W, 6, width of pixels-per-line field; active pixels per line = 16*(ppl+1)
- LPP_W, 10, width of lines-per-panel field; active lines = lpp+1

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  reset; asynchronous, active-low
- pclk_en  in  1  one-HCLK pixel-clock tick; all raster counters advance only when high
- lcd_en  in  1  LCD_CTRL.LcdEn
- ppl  in  PPL_W  LCD_TIMH.PPL
- hsw, hbp, hfp  in  8 each  LCD_TIMH sync width / back porch / front porch
- lpp  in  LPP_W  LCD_TIMV.LPP
- vsw  in  6  LCD_TIMV sync width
- vbp, vfp  in  8 each  LCD_TIMV back / front porch
- ihs, ivs, ioe  in  1 each  LCD_POL invert line pulse / frame pulse / enable
- vcomp_sel  in  2  LCD_CTRL.LcdVComp: 0 = vsync start, 1 = back-porch start, 2 = active start, 3 = front-porch start
- lcd_lp  out  1  line pulse (hsync)
- lcd_fp  out  1  frame pulse (vsync)
- lcd_ena  out  1  data enable
- pix_req  out  1  one-HCLK request per active pixel
- lnbu_pulse  out  1  base-address update strobe, to LCD_INTRAW.LNBU
- vcomp_pulse  out  1  vertical-compare strobe, to LCD_INTRAW.VComp
- busy  out  1  raster running
- line_cnt  out  LPP_W  current active line index

Behaviour:
- Reset: H/V state = IDLE, all counters 0, shadow regs 0.
  - lcd_lp = ihs, lcd_fp = ivs, lcd_ena = ioe (deasserted levels).
  - pix_req, lnbu_pulse, vcomp_pulse, busy = 0; line_cnt = 0.
- Shadowing: all timing and polarity inputs are latched into shadow regs on entry to V_SYNC. Mid-frame register writes take effect at the next frame.
- Horizontal FSM (advances on pclk_en only):
  - H_SYNC for hsw+1 ticks, then H_BACK for hbp+1 ticks, then H_ACTIVE for 16*(ppl+1) ticks, then H_FRONT for hfp+1 ticks, then back to H_SYNC.
  - Line length = hsw+hbp+hfp+3+16*(ppl+1) ticks.
  - Counter width 12 bits; no wrap possible at maximum fields.
- Vertical FSM (advances at the final tick of H_FRONT):
  - V_SYNC for vsw+1 lines, V_BACK for vbp lines, V_ACTIVE for lpp+1 lines, V_FRONT for vfp lines.
  - A zero-length state (vbp = 0 or vfp = 0) is skipped in the same transition.
  - After V_FRONT, returns to V_SYNC.
- Start: from IDLE, lcd_en = 1 at any pclk_en tick → H_SYNC/V_SYNC on that tick; busy = 1 from the same HCLK edge.
- Stop: lcd_en = 0 mid-frame → current frame completes. At the end of the last V_FRONT line (or last V_ACTIVE line if vfp = 0), go to IDLE and set busy = 0. If lcd_en returns to 1 before the frame ends, continue without a gap.
- Outputs are registered, updated on the HCLK edge of the pclk_en tick that changes state:
  - lcd_lp = (H == H_SYNC) XOR ihs.
  - lcd_fp = (V == V_SYNC) XOR ivs.
  - lcd_ena = (H == H_ACTIVE && V == V_ACTIVE) XOR ioe.
- pix_req = pclk_en AND registered state is H_ACTIVE and V_ACTIVE. Exactly 16*(ppl+1) requests per active line; none in porches, sync or IDLE.
- lnbu_pulse: one HCLK high on every V_SYNC entry, including the first.
- vcomp_pulse: one HCLK high on entry to the V state selected by vcomp_sel, sampled from the shadow copy. If the selected state is skipped (length 0), pulse on entry to the following state instead.
- line_cnt: 0 at V_ACTIVE entry, +1 at each active line end, holds lpp in V_FRONT, cleared at V_SYNC.
- pclk_en low: all state and outputs hold; pulses stay low.
- Async reset mid-frame: immediate return to reset values; no pulse emitted.

Test Plan:
- Basic frame: ppl=0, hsw=1, hbp=2, hfp=3, lpp=1, vsw=0, vbp=1, vfp=1, pclk_en=1 constantly, lcd_en raised.
  - Line = 25 HCLK, lcd_lp high 2 cycles per line.
  - Frame = 5 lines = 125 cycles, lcd_fp high for the first 25.
  - lcd_ena high 16 cycles on lines 3–4 only; 32 pix_req per frame.
- Same setup with pclk_en every 4th cycle → all durations exactly 4×, pix_req still 32 per frame, each coincident with pclk_en.
- vbp=0, vfp=0, vcomp_sel=1 → V_BACK skipped; vcomp_pulse fires on V_ACTIVE entry at cycle 25; frame = 75 cycles.
- ihs=ivs=ioe=1 → all three outputs inverted at reset and throughout; timing identical to the first test.
- Drop lcd_en at cycle 40 → frame completes, busy falls at cycle 125, then no further lnbu_pulse. Write hsw=5 mid-frame → line length changes only from the next frame (if re-enabled).
- Assert HRESETn low during H_ACTIVE → same edge: lcd_ena = ioe, pix_req = 0, line_cnt = 0, busy = 0.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// Raster timing sequencer: line/frame/enable pulses, pixel-fetch requests and
// frame strobes, stepped by pixel-clock enable ticks.
module lcd_timing_gen #(
    parameter int PPL_W = 6,
    parameter int LPP_W = 10
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             pclk_en,
    input  logic             lcd_en,
    input  logic [PPL_W-1:0] ppl,
    input  logic [7:0]       hsw,
    input  logic [7:0]       hbp,
    input  logic [7:0]       hfp,
    input  logic [LPP_W-1:0] lpp,
    input  logic [5:0]       vsw,
    input  logic [7:0]       vbp,
    input  logic [7:0]       vfp,
    input  logic             ihs,
    input  logic             ivs,
    input  logic             ioe,
    input  logic [1:0]       vcomp_sel,
    output logic             lcd_lp,
    output logic             lcd_fp,
    output logic             lcd_ena,
    output logic             pix_req,
    output logic             lnbu_pulse,
    output logic             vcomp_pulse,
    output logic             busy,
    output logic [LPP_W-1:0] line_cnt
);

    typedef enum logic [2:0] {H_IDLE, H_SYNC, H_BACK, H_ACTIVE, H_FRONT} h_state_e;
    typedef enum logic [2:0] {V_IDLE, V_SYNC, V_BACK, V_ACTIVE, V_FRONT} v_state_e;

    typedef struct packed {
        logic [PPL_W-1:0] ppl;
        logic [7:0]       hsw;
        logic [7:0]       hbp;
        logic [7:0]       hfp;
        logic [LPP_W-1:0] lpp;
        logic [5:0]       vsw;
        logic [7:0]       vbp;
        logic [7:0]       vfp;
        logic             ihs;
        logic             ivs;
        logic             ioe;
        logic [1:0]       vcomp_sel;
    } timing_t;

    timing_t          live_cfg, sh_q, sh_d;
    h_state_e         h_q, h_d;
    v_state_e         v_q, v_d, tgt;
    logic [11:0]      h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [LPP_W-1:0] line_cnt_q, line_cnt_d;
    logic             busy_q, busy_d, lnbu_q, lnbu_d, vcomp_q, vcomp_d;
    logic             lp_q, lp_d, fp_q, fp_d, ena_q, ena_d;
    logic             v_entry, line_end;

    assign live_cfg = '{ppl: ppl, hsw: hsw, hbp: hbp, hfp: hfp, lpp: lpp, vsw: vsw,
                        vbp: vbp, vfp: vfp, ihs: ihs, ivs: ivs, ioe: ioe,
                        vcomp_sel: vcomp_sel};

    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        line_cnt_d = line_cnt_q;
        busy_d     = busy_q;
        sh_d       = sh_q;
        v_entry    = 1'b0;
        line_end   = 1'b0;
        tgt        = V_SYNC;
        if (pclk_en) begin
            if (h_q == H_IDLE) begin
                if (lcd_en) begin
                    h_d     = H_SYNC;
                    v_d     = V_SYNC;
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                    busy_d  = 1'b1;
                    v_entry = 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
                case (h_q)
                    H_SYNC:   if (h_cnt_q == 12'(sh_q.hsw)) begin h_d = H_BACK; h_cnt_d = '0; end
                    H_BACK:   if (h_cnt_q == 12'(sh_q.hbp)) begin h_d = H_ACTIVE; h_cnt_d = '0; end
                    H_ACTIVE: if (h_cnt_q == 12'({sh_q.ppl, 4'hF})) begin h_d = H_FRONT; h_cnt_d = '0; end
                    H_FRONT:  if (h_cnt_q == 12'(sh_q.hfp)) begin
                        h_d      = H_SYNC;
                        h_cnt_d  = '0;
                        line_end = 1'b1;
                    end
                    default: ;
                endcase
                if (line_end) begin
                    v_cnt_d = v_cnt_q + 12'd1;
                    case (v_q)
                        V_SYNC: if (v_cnt_q == 12'(sh_q.vsw)) begin
                            v_d        = (sh_q.vbp != 8'd0) ? V_BACK : V_ACTIVE;
                            v_cnt_d    = '0;
                            line_cnt_d = '0;
                            v_entry    = 1'b1;
                        end
                        V_BACK: if (v_cnt_q == 12'(sh_q.vbp) - 12'd1) begin
                            v_d        = V_ACTIVE;
                            v_cnt_d    = '0;
                            line_cnt_d = '0;
                            v_entry    = 1'b1;
                        end
                        V_ACTIVE: begin
                            if (line_cnt_q == sh_q.lpp) begin
                                v_cnt_d = '0;
                                if (sh_q.vfp != 8'd0) begin
                                    v_d     = V_FRONT;
                                    v_entry = 1'b1;
                                end else if (lcd_en) begin
                                    v_d     = V_SYNC;
                                    v_entry = 1'b1;
                                end else begin
                                    v_d = V_IDLE;
                                end
                            end else begin
                                line_cnt_d = line_cnt_q + LPP_W'(1);
                            end
                        end
                        V_FRONT: if (v_cnt_q == 12'(sh_q.vfp) - 12'd1) begin
                            v_cnt_d = '0;
                            if (lcd_en) begin
                                v_d     = V_SYNC;
                                v_entry = 1'b1;
                            end else begin
                                v_d = V_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
        if (v_d == V_IDLE) begin
            h_d        = H_IDLE;
            h_cnt_d    = '0;
            v_cnt_d    = '0;
            line_cnt_d = '0;
            busy_d     = 1'b0;
        end
        // New frame: register writes made during the last frame land here
        if (v_entry && v_d == V_SYNC) begin
            sh_d       = live_cfg;
            line_cnt_d = '0;
        end
        case (sh_d.vcomp_sel)
            2'd0:    tgt = V_SYNC;
            2'd1:    tgt = (sh_d.vbp != 8'd0) ? V_BACK : V_ACTIVE;
            2'd2:    tgt = V_ACTIVE;
            default: tgt = (sh_d.vfp != 8'd0) ? V_FRONT : V_SYNC;
        endcase
        lnbu_d  = v_entry && (v_d == V_SYNC);
        vcomp_d = v_entry && (v_d == tgt);
        lp_d    = (h_d == H_SYNC);
        fp_d    = (v_d == V_SYNC);
        ena_d   = (h_d == H_ACTIVE) && (v_d == V_ACTIVE);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            h_q        <= H_IDLE;
            v_q        <= V_IDLE;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            line_cnt_q <= '0;
            sh_q       <= '0;
            busy_q     <= 1'b0;
            lnbu_q     <= 1'b0;
            vcomp_q    <= 1'b0;
            lp_q       <= 1'b0;
            fp_q       <= 1'b0;
            ena_q      <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            line_cnt_q <= line_cnt_d;
            sh_q       <= sh_d;
            busy_q     <= busy_d;
            lnbu_q     <= lnbu_d;
            vcomp_q    <= vcomp_d;
            lp_q       <= lp_d;
            fp_q       <= fp_d;
            ena_q      <= ena_d;
        end
    end

    // Idle panels follow the live polarity bits; a running frame uses its shadow copy
    assign lcd_lp      = lp_q  ^ (busy_q ? sh_q.ihs : ihs);
    assign lcd_fp      = fp_q  ^ (busy_q ? sh_q.ivs : ivs);
    assign lcd_ena     = ena_q ^ (busy_q ? sh_q.ioe : ioe);
    assign pix_req     = pclk_en && (h_q == H_ACTIVE) && (v_q == V_ACTIVE);
    assign lnbu_pulse  = lnbu_q;
    assign vcomp_pulse = vcomp_q;
    assign busy        = busy_q;
    assign line_cnt    = line_cnt_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen; expected outputs come from raster
// position arithmetic (line = t / L, pos = t % L) queued per cycle.
module tb_lcd_timing_gen;
    localparam int PPL_W = 6;
    localparam int LPP_W = 10;

    logic             HCLK = 1'b0, HRESETn = 1'b0, pclk_en = 1'b0, lcd_en = 1'b0;
    logic [PPL_W-1:0] ppl;
    logic [7:0]       hsw, hbp, hfp, vbp, vfp;
    logic [LPP_W-1:0] lpp;
    logic [5:0]       vsw;
    logic             ihs, ivs, ioe;
    logic [1:0]       vcomp_sel;
    logic             lcd_lp, lcd_fp, lcd_ena, pix_req, lnbu_pulse, vcomp_pulse, busy;
    logic [LPP_W-1:0] line_cnt;

    always #5 HCLK = ~HCLK;

    lcd_timing_gen #(.PPL_W(PPL_W), .LPP_W(LPP_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .pclk_en(pclk_en), .lcd_en(lcd_en),
        .ppl(ppl), .hsw(hsw), .hbp(hbp), .hfp(hfp), .lpp(lpp), .vsw(vsw),
        .vbp(vbp), .vfp(vfp), .ihs(ihs), .ivs(ivs), .ioe(ioe), .vcomp_sel(vcomp_sel),
        .lcd_lp(lcd_lp), .lcd_fp(lcd_fp), .lcd_ena(lcd_ena), .pix_req(pix_req),
        .lnbu_pulse(lnbu_pulse), .vcomp_pulse(vcomp_pulse), .busy(busy), .line_cnt(line_cnt)
    );

    typedef struct {
        int ppl, hsw, hbp, hfp, lpp, vsw, vbp, vfp, sel;
        bit ihs, ivs, ioe;
    } cfg_t;

    cfg_t        live, sh, base;
    bit          running, ticked;
    int          t, cyc, checks, errors, pix_cnt, lnbu_cnt;
    string       tname;
    logic [16:0] exp_q[$];

    task automatic apply_cfg(input cfg_t c);
        live      = c;
        ppl       = PPL_W'(c.ppl);
        hsw       = 8'(c.hsw);
        hbp       = 8'(c.hbp);
        hfp       = 8'(c.hfp);
        lpp       = LPP_W'(c.lpp);
        vsw       = 6'(c.vsw);
        vbp       = 8'(c.vbp);
        vfp       = 8'(c.vfp);
        ihs       = c.ihs;
        ivs       = c.ivs;
        ioe       = c.ioe;
        vcomp_sel = 2'(c.sel);
    endtask

    function automatic int line_len(input cfg_t c);
        return c.hsw + c.hbp + c.hfp + 3 + 16 * (c.ppl + 1);
    endfunction

    function automatic int n_lines(input cfg_t c);
        return c.vsw + 1 + c.vbp + c.lpp + 1 + c.vfp;
    endfunction

    // {lp, fp, ena, pix_req, lnbu, vcomp, busy, line_cnt}
    function automatic logic [16:0] expect_vec(input bit pen);
        int L, nl, line, pos, a0, h0, tgt, lc;
        bit hact, vact, lnbu, vc;
        if (!running) return {live.ihs, live.ivs, live.ioe, 4'b0000, 10'd0};
        L    = line_len(sh);
        nl   = n_lines(sh);
        line = t / L;
        pos  = t % L;
        a0   = sh.vsw + 1 + sh.vbp;
        h0   = sh.hsw + sh.hbp + 2;
        hact = (pos >= h0) && (pos < h0 + 16 * (sh.ppl + 1));
        vact = (line >= a0) && (line <= a0 + sh.lpp);
        lc   = (line < a0) ? 0 : (vact ? line - a0 : sh.lpp);
        case (sh.sel)
            0:       tgt = 0;
            1:       tgt = sh.vsw + 1;
            2:       tgt = a0;
            default: tgt = (a0 + sh.lpp + 1) % nl;
        endcase
        lnbu = ticked && (t == 0);
        vc   = ticked && (pos == 0) && (line == tgt);
        return {(pos < sh.hsw + 1) ^ sh.ihs, (line < sh.vsw + 1) ^ sh.ivs,
                (hact && vact) ^ sh.ioe, pen && hact && vact, lnbu, vc, 1'b1, lc[9:0]};
    endfunction

    // Runs from one negedge to the next: drive, check, advance the model on the edge
    task automatic step(input bit pen, input bit en);
        logic [16:0] got, exp;
        pclk_en = pen;
        lcd_en  = en;
        #1;
        exp_q.push_back(expect_vec(pen));
        got = {lcd_lp, lcd_fp, lcd_ena, pix_req, lnbu_pulse, vcomp_pulse, busy, line_cnt};
        exp = exp_q.pop_front();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tname, cyc, got, exp);
        end
        if (pix_req === 1'b1) pix_cnt++;
        if (lnbu_pulse === 1'b1) lnbu_cnt++;
        @(posedge HCLK);
        ticked = pen;
        if (pen) begin
            if (running) begin
                t++;
                if (t == line_len(sh) * n_lines(sh)) begin
                    if (en) begin t = 0; sh = live; end
                    else running = 0;
                end
            end else if (en) begin
                running = 1;
                t       = 0;
                sh      = live;
            end
        end
        cyc++;
        @(negedge HCLK);
    endtask

    task automatic do_reset(input string name);
        logic [16:0] got, exp;
        tname   = name;
        HRESETn = 1'b0;
        pclk_en = 1'b0;
        lcd_en  = 1'b0;
        running = 0;
        ticked  = 0;
        #1;
        exp = expect_vec(1'b0);
        got = {lcd_lp, lcd_fp, lcd_ena, pix_req, lnbu_pulse, vcomp_pulse, busy, line_cnt};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s_reset observed=%h expected=%h", name, got, exp);
        end
        @(negedge HCLK);
        HRESETn  = 1'b1;
        cyc      = 0;
        pix_cnt  = 0;
        lnbu_cnt = 0;
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        cfg_t c;
        checks = 0;
        errors = 0;
        base = '{ppl: 0, hsw: 1, hbp: 2, hfp: 3, lpp: 1, vsw: 0, vbp: 1, vfp: 1,
                 sel: 0, ihs: 1'b0, ivs: 1'b0, ioe: 1'b0};
        apply_cfg(base);
        @(negedge HCLK);

        // Basic frame: 25-cycle lines, 5-line frame, 32 pixel requests
        do_reset("basic");
        for (int i = 0; i < 125; i++) step(1'b1, 1'b1);
        check_int("basic_pix_per_frame", pix_cnt, 32);
        for (int i = 0; i < 130; i++) step(1'b1, 1'b1);
        check_int("basic_lnbu_two_frames", lnbu_cnt, 3);

        // Pixel clock at 1/4 rate
        do_reset("pclk4");
        for (int i = 0; i < 520; i++) step(i % 4 == 0, 1'b1);
        check_int("pclk4_pix_per_frame", pix_cnt, 32);

        // Zero-length porches, vcomp on back-porch start falls to active start
        c = base; c.vbp = 0; c.vfp = 0; c.sel = 1;
        apply_cfg(c);
        do_reset("skip");
        for (int i = 0; i < 160; i++) step(1'b1, 1'b1);

        // Inverted polarities
        c = base; c.ihs = 1; c.ivs = 1; c.ioe = 1; c.sel = 3;
        apply_cfg(c);
        do_reset("inv");
        for (int i = 0; i < 130; i++) step(1'b1, 1'b1);

        // Stop mid-frame with a register write, then restart with the new line length
        c = base; c.sel = 2;
        apply_cfg(c);
        do_reset("stop");
        for (int i = 0; i < 140; i++) begin
            if (i == 40) begin c.hsw = 5; apply_cfg(c); end
            if (i == 126) lnbu_cnt = 0;
            step(1'b1, i < 40);
        end
        check_int("stop_no_lnbu_after_idle", lnbu_cnt, 0);
        tname = "restart";
        for (int i = 0; i < 150; i++) step(1'b1, 1'b1);
        tname = "en_glitch";
        for (int i = 0; i < 200; i++) step(1'b1, !(i >= 20 && i < 60));

        // Async reset in the middle of an active pixel run
        apply_cfg(base);
        do_reset("rst");
        for (int i = 0; i < 61; i++) step(1'b1, 1'b1);
        pclk_en = 1'b1;
        HRESETn = 1'b0;
        #1;
        checks++;
        assert ({lcd_ena, pix_req, busy, line_cnt} === {base.ioe, 1'b0, 1'b0, 10'd0}) else begin
            errors++;
            $error("FAIL rst_mid_active observed=%b expected=%b",
                   {lcd_ena, pix_req, busy, line_cnt}, {base.ioe, 1'b0, 1'b0, 10'd0});
        end
        running = 0;
        ticked  = 0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        tname = "post_rst";
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
